// File: rtl/my_div_unit_if.sv
// Handshake and result bundle between the CPU control unit (master) and my_div_unit (slave).
interface my_div_unit_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  start;
   logic [DATA_WIDTH-1:0] dividend;
   logic [DATA_WIDTH-1:0] divisor;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] quotient;
   logic [DATA_WIDTH-1:0] remainder;
   logic                  div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/my_div_unit.sv
// Sequential restoring divider, one quotient bit per clock.
// Define MY_DIV_SIGNED_EN for two's-complement operands (sign fix applied when results load).
module my_div_unit #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input logic         clk,
   input logic         rst,
   my_div_unit_if.slave bus
);
   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  rem_q, rem_d;
   logic [W-1:0]  dvd_q, dvd_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          dbz_q, dbz_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [W-1:0]  res_rem_q, res_rem_d;
`ifdef MY_DIV_SIGNED_EN
   logic          qneg_q, qneg_d;
   logic          rneg_q, rneg_d;

   function automatic logic [W-1:0] negate(input logic [W-1:0] v);
      return ~v + W'(1);
   endfunction

   function automatic logic [W-1:0] mag(input logic [W-1:0] v);
      return v[W-1] ? negate(v) : v;
   endfunction
`endif

   logic [W:0]    shifted;
   logic [W:0]    trial;
   logic [W-1:0]  step_rem;
   logic [W-1:0]  step_quo;

   // One restoring step; shifted keeps the carried-out bit so the trial never truncates.
   always_comb begin
      shifted  = {rem_q, dvd_q[W-1]};
      trial    = shifted - {1'b0, dvs_q};
      step_quo = {dvd_q[W-2:0], ~trial[W]};
      step_rem = trial[W] ? shifted[W-1:0] : trial[W-1:0];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      dbz_d     = dbz_q;
      quo_d     = quo_q;
      res_rem_d = res_rem_q;
`ifdef MY_DIV_SIGNED_EN
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.divisor == '0) begin
                  quo_d     = '1;
                  res_rem_d = bus.dividend;
                  dbz_d     = 1'b1;
                  done_d    = 1'b1;
               end else begin
`ifdef MY_DIV_SIGNED_EN
                  dvd_d  = mag(bus.dividend);
                  dvs_d  = mag(bus.divisor);
                  qneg_d = bus.dividend[W-1] ^ bus.divisor[W-1];
                  rneg_d = bus.dividend[W-1];
`else
                  dvd_d  = bus.dividend;
                  dvs_d  = bus.divisor;
`endif
                  rem_d   = '0;
                  cnt_d   = CW'(W);
                  state_d = RUN;
                  busy_d  = 1'b1;
               end
            end
         end
         RUN: begin
            rem_d = step_rem;
            dvd_d = step_quo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               dbz_d   = 1'b0;
`ifdef MY_DIV_SIGNED_EN
               quo_d     = qneg_q ? negate(step_quo) : step_quo;
               res_rem_d = rneg_q ? negate(step_rem) : step_rem;
`else
               quo_d     = step_quo;
               res_rem_d = step_rem;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         quo_q     <= '0;
         res_rem_q <= '0;
`ifdef MY_DIV_SIGNED_EN
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
         quo_q     <= quo_d;
         res_rem_q <= res_rem_d;
`ifdef MY_DIV_SIGNED_EN
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
`endif
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.quotient    = quo_q;
   assign bus.remainder   = res_rem_q;
endmodule

// File: tb/tb_my_div_unit.sv
// Self-checking bench for my_div_unit: directed table, multi-cycle corner sequences, random vs model.
module tb_my_div_unit;
   localparam int unsigned W = 8;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   my_div_unit_if #(.DATA_WIDTH(W)) bus ();
   my_div_unit #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } vec_t;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } res_t;

   // Behavioural reference: plain integer division semantics.
   function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      res_t res;
      int   sa;
      int   sb;
      sa = 0;
      sb = 0;
      if (b == '0) begin
         res.q   = '1;
         res.r   = a;
         res.dbz = 1'b1;
      end else begin
`ifdef MY_DIV_SIGNED_EN
         sa    = $signed(a);
         sb    = $signed(b);
         res.q = W'(sa / sb);
         res.r = W'(sa % sb);
`else
         sa    = int'(a);
         sb    = int'(b);
         res.q = W'(sa / sb);
         res.r = W'(sa % sb);
`endif
         res.dbz = 1'b0;
      end
      return res;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Called at a negedge: present a request, hold it across one rising edge, then drop it.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Counts cycles after E0 until done; optionally pokes a start at cycle poke_at.
   task automatic wait_done(input int poke_at, output int c, output bit busy_ok);
      c       = 0;
      busy_ok = 1'b1;
      while (!bus.done && c < 40) begin
         if (!bus.busy) busy_ok = 1'b0;
         if (c == poke_at) begin
            bus.start    = 1'b1;
            bus.dividend = 8'd9;
            bus.divisor  = 8'd3;
         end else begin
            bus.start = 1'b0;
         end
         c++;
         @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   task automatic check_result(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int c, input bit busy_ok);
      res_t e;
      e = ref_div(a, b);
      check({name, "_latency"}, c, (b == '0) ? 0 : int'(W));
      check({name, "_busy_run"}, int'(busy_ok), 1);
      check({name, "_busy_at_done"}, int'(bus.busy), 0);
      check({name, "_q"}, int'(bus.quotient), int'(e.q));
      check({name, "_r"}, int'(bus.remainder), int'(e.r));
      check({name, "_dbz"}, int'(bus.div_by_zero), int'(e.dbz));
   endtask

   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int poke_at);
      int c;
      bit ok;
      start_op(a, b);
      wait_done(poke_at, c, ok);
      check_result(name, a, b, c, ok);
      @(negedge clk);
      check({name, "_done_single"}, int'(bus.done), 0);
      check({name, "_idle_after"}, int'(bus.busy), 0);
   endtask

   vec_t vecs[$];

   initial begin
      int   c;
      bit   ok;
      bit   saw_done;
      res_t e;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      total = 0;
      bad   = 0;
`ifdef MY_DIV_SIGNED_EN
      vecs.push_back('{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0});
      vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});
      vecs.push_back('{8'd55, 8'h00, 8'hFF, 8'd55, 1'b1});
      vecs.push_back('{8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0});
      vecs.push_back('{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0});
      vecs.push_back('{8'h80, 8'h01, 8'h80, 8'h00, 1'b0});
      vecs.push_back('{8'h7F, 8'hFF, 8'h81, 8'h00, 1'b0});
      vecs.push_back('{8'h9C, 8'h00, 8'hFF, 8'h9C, 1'b1});
`else
      vecs.push_back('{8'd200, 8'd7, 8'd28, 8'd4, 1'b0});
      vecs.push_back('{8'd55, 8'd0, 8'hFF, 8'd55, 1'b1});
      vecs.push_back('{8'd255, 8'd16, 8'd15, 8'd15, 1'b0});
      vecs.push_back('{8'd100, 8'd10, 8'd10, 8'd0, 1'b0});
      vecs.push_back('{8'd0, 8'd5, 8'd0, 8'd0, 1'b0});
      vecs.push_back('{8'd255, 8'd1, 8'd255, 8'd0, 1'b0});
      vecs.push_back('{8'd7, 8'd200, 8'd0, 8'd7, 1'b0});
      vecs.push_back('{8'd255, 8'd255, 8'd1, 8'd0, 1'b0});
      vecs.push_back('{8'd128, 8'd255, 8'd0, 8'd128, 1'b0});
`endif

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
      check("reset_q", int'(bus.quotient), 0);
      check("reset_r", int'(bus.remainder), 0);
      check("reset_dbz", int'(bus.div_by_zero), 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed table with constant expectations.
      foreach (vecs[i]) begin
         start_op(vecs[i].a, vecs[i].b);
         wait_done(-1, c, ok);
         check($sformatf("vec%0d_latency", i), c, (vecs[i].b == '0) ? 0 : int'(W));
         check($sformatf("vec%0d_busy_run", i), int'(ok), 1);
         check($sformatf("vec%0d_q", i), int'(bus.quotient), int'(vecs[i].q));
         check($sformatf("vec%0d_r", i), int'(bus.remainder), int'(vecs[i].r));
         check($sformatf("vec%0d_dbz", i), int'(bus.div_by_zero), int'(vecs[i].dbz));
         @(negedge clk);
         check($sformatf("vec%0d_done_single", i), int'(bus.done), 0);
      end

      // start pulsed mid-run (sampled at E3) must be ignored.
      run_op("ignore_start", 8'd200, 8'd7, 2);

      // Back-to-back: second start presented in the first done cycle.
      start_op(8'd255, 8'd16);
      wait_done(-1, c, ok);
      check_result("b2b_first", 8'd255, 8'd16, c, ok);
      start_op(8'd100, 8'd10);
      wait_done(-1, c, ok);
      check_result("b2b_second", 8'd100, 8'd10, c, ok);
      @(negedge clk);

      // Back-to-back divide-by-zero requests give consecutive done cycles.
      bus.start    = 1'b1;
      bus.dividend = 8'd33;
      bus.divisor  = 8'd0;
      @(negedge clk);
      check("dbz_b2b_done1", int'(bus.done), 1);
      bus.dividend = 8'd44;
      @(negedge clk);
      bus.start = 1'b0;
      check("dbz_b2b_done2", int'(bus.done), 1);
      check("dbz_b2b_r", int'(bus.remainder), 44);
      check("dbz_b2b_busy", int'(bus.busy), 0);
      @(negedge clk);

      // Asynchronous reset mid-run discards the operation.
      start_op(8'd200, 8'd7);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_busy", int'(bus.busy), 0);
      check("rst_mid_done", int'(bus.done), 0);
      check("rst_mid_q", int'(bus.quotient), 0);
      check("rst_mid_r", int'(bus.remainder), 0);
      check("rst_mid_dbz", int'(bus.div_by_zero), 0);
      @(negedge clk);
      rst      = 1'b0;
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done || bus.busy) saw_done = 1'b1;
      end
      check("rst_mid_no_done", int'(saw_done), 0);

      // Random operands against the reference model.
      for (int n = 0; n < 40; n++) begin
         ra = W'($urandom_range(0, 255));
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
         run_op($sformatf("rand%0d", n), ra, rb, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
